// File: rtl/uart_rx_lm.sv
// uart_rx_lm: 8-bit LSB-first UART receiver with optional even parity and framing/break detection.
// Strobes fire the cycle after the stop-bit mid-sample.
module uart_rx_lm #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] UART_data,
  output logic       UART_data_valid,
  output logic [1:0] UART_errors,
  output logic       UART_errors_valid
);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t      r_state, w_next;
  logic        r_rx_meta, r_rx_s, r_rx_prev;
  logic [2:0]  r_fill;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par_err;
  logic        w_fall, w_tick;
  // edge detection stays disarmed until the synchronizer holds real line values after reset
  assign w_fall = r_fill[2] & r_rx_prev & ~r_rx_s;
  assign w_tick = r_cnt == ((r_state == START) ? HALF : LAST);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fall ? START : IDLE;
      START:   w_next = !w_tick ? START : (r_rx_s ? IDLE : DATA);
      DATA:    w_next = (w_tick && r_bit == 3'd7) ? (PARITY_EN ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_tick ? STOP : PARITY;
      STOP:    w_next = !w_tick ? STOP : (r_rx_s ? IDLE : BREAK);
      BREAK:   w_next = r_rx_s ? IDLE : BREAK;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_rx_meta         <= 1'b1;
      r_rx_s            <= 1'b1;
      r_rx_prev         <= 1'b1;
      r_fill            <= '0;
      r_cnt             <= '0;
      r_bit             <= '0;
      r_shift           <= '0;
      r_par_err         <= 1'b0;
      UART_data         <= '0;
      UART_data_valid   <= 1'b0;
      UART_errors       <= '0;
      UART_errors_valid <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_rx_meta         <= rx;
      r_rx_s            <= r_rx_meta;
      r_rx_prev         <= r_rx_s;
      r_fill            <= {r_fill[1:0], 1'b1};
      r_cnt             <= (r_state == IDLE || r_state == BREAK || w_tick) ? '0 : r_cnt + 16'd1;
      UART_data_valid   <= 1'b0;
      UART_errors_valid <= 1'b0;
      if (r_state == START) begin
        r_bit     <= '0;
        r_par_err <= 1'b0;
      end
      if (r_state == DATA && w_tick) begin
        r_shift <= {r_rx_s, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (r_state == PARITY && w_tick) r_par_err <= ^r_shift ^ r_rx_s;
      if (r_state == STOP && w_tick) begin
        UART_errors       <= {~r_rx_s, r_par_err};
        UART_errors_valid <= 1'b1;
        if (r_rx_s && !r_par_err) begin
          UART_data       <= r_shift;
          UART_data_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_lm.sv
// tb_uart_rx_lm: scoreboard bench for uart_rx_lm (parity instance u0, no-parity instance u1).
module tb_uart_rx_lm;
  localparam int CPB = 16;
  typedef struct {logic [1:0] err; logic dv; logic [7:0] data;} exp_t;
  logic clk = 0, rst = 1, rx = 1, rx1 = 1;
  logic [7:0] d0, d1;
  logic dv0, dv1, ev0, ev1;
  logic [1:0] e0, e1;
  exp_t q[$];
  int t1_cyc[$];
  logic [7:0] t1_data[$];
  logic [7:0] exp_data = 8'h00;
  int n_checks = 0, n_err = 0, n_strb = 0, cyc = 0;

  uart_rx_lm #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx), .UART_data(d0), .UART_data_valid(dv0),
    .UART_errors(e0), .UART_errors_valid(ev0));
  uart_rx_lm #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .UART_data(d1), .UART_data_valid(dv1),
    .UART_errors(e1), .UART_errors_valid(ev1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (dv1) begin
      t1_cyc.push_back(cyc);
      t1_data.push_back(d1);
    end
    if (ev0) begin
      n_strb++;
      n_checks++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: errors=%b data_valid=%b, no frame outstanding", e0, dv0);
      end else begin
        e = q.pop_front();
        if (e0 !== e.err) begin
          n_err++;
          $display("FAIL errors: got %b expected %b", e0, e.err);
        end
        n_checks++;
        if (dv0 !== e.dv) begin
          n_err++;
          $display("FAIL data_valid: got %b expected %b", dv0, e.dv);
        end
        if (e.dv) exp_data = e.data;
        n_checks++;
        if (d0 !== exp_data) begin
          n_err++;
          $display("FAIL data: got %h expected %h", d0, exp_data);
        end
      end
    end else if (dv0) begin
      n_strb++;
      n_checks++;
      n_err++;
      $display("FAIL lone_data_valid: data_valid=1 errors_valid=%b", ev0);
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drive_bit1(input logic b);
    rx1 = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    exp_t e;
    e.err  = {~stp, par ^ (^d)};
    e.dv   = (e.err == 2'b00);
    e.data = d;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: %0d frames outstanding, expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({d0, e0, dv0, ev0} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: data=%h errors=%b dv=%b ev=%b, expected all 0", d0, e0, dv0, ev0);
    end
    rst = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    wait_drain("good");
  endtask

  task automatic test_parity;
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    wait_drain("parity");
    repeat (50) @(negedge clk);
    n_checks++;
    if (e0 !== 2'b01 || d0 !== 8'hA5) begin
      n_err++;
      $display("FAIL parity_hold: errors=%b data=%h expected 01 a5", e0, d0);
    end
  endtask

  task automatic test_break;
    int s0 = n_strb;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    rx = 1;
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (n_strb - s0 != 1) begin
      n_err++;
      $display("FAIL break_strobes: got %0d expected 1", n_strb - s0);
    end
    wait_drain("break");
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    wait_drain("after_break");
  endtask

  task automatic test_glitch;
    int s0 = n_strb;
    rx = 0;
    repeat (5) @(negedge clk);
    rx = 1;
    repeat (4 * CPB) @(negedge clk);
    n_checks++;
    if (n_strb != s0) begin
      n_err++;
      $display("FAIL glitch_strobes: got %0d expected 0", n_strb - s0);
    end
    send_frame(8'hC3, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    wait_drain("after_glitch");
  endtask

  task automatic test_reset_mid;
    int s0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({d0, e0, dv0, ev0} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_mid_outputs: data=%h errors=%b dv=%b ev=%b, expected all 0", d0, e0, dv0, ev0);
    end
    rst = 0;
    exp_data = 8'h00;
    s0 = n_strb;
    repeat (12 * CPB) @(negedge clk);
    n_checks++;
    if (n_strb != s0 || d0 !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_quiet: strobes=%0d data=%h expected 0 00", n_strb - s0, d0);
    end
    send_frame(8'h12, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    wait_drain("after_reset");
  endtask

  task automatic test_back_to_back;
    logic [7:0] v [2];
    v[0] = 8'h80;
    v[1] = 8'h7F;
    t1_cyc.delete();
    t1_data.delete();
    for (int f = 0; f < 2; f++) begin
      drive_bit1(1'b0);
      for (int i = 0; i < 8; i++) drive_bit1(v[f][i]);
      drive_bit1(1'b1);
    end
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (t1_data.size() != 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d strobes expected 2", t1_data.size());
    end else begin
      n_checks++;
      if (t1_data[0] !== 8'h80 || t1_data[1] !== 8'h7F) begin
        n_err++;
        $display("FAIL b2b_data: got %h %h expected 80 7f", t1_data[0], t1_data[1]);
      end
      n_checks++;
      if (t1_cyc[1] - t1_cyc[0] != 10 * CPB) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d expected %0d", t1_cyc[1] - t1_cyc[0], 10 * CPB);
      end
    end
    n_checks++;
    if (e1 !== 2'b00 || d1 !== 8'h7F) begin
      n_err++;
      $display("FAIL b2b_final: errors=%b data=%h expected 00 7f", e1, d1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good();
    test_parity();
    test_break();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_lm.md
UART_RX_LM -- requirements
Module: uart_rx_lm

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter: PARITY_EN, default 1, 1 = even-parity bit present between data and stop, 0 = no parity bit.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first.
REQ-006 Port: UART_data  output  8  last correctly received byte.
REQ-007 Port: UART_data_valid  output  1  one-cycle strobe, UART_data updated this cycle.
REQ-008 Port: UART_errors  output  2  bit0 parity error, bit1 framing error, for the last frame.
REQ-009 Port: UART_errors_valid  output  1  one-cycle strobe at the end of every completed frame.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized signal rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-012 Bit counter SHALL be 16 bits; mid-bit point = (CLKS_PER_BIT-1)/2 cycles after the falling edge; later samples every CLKS_PER_BIT cycles.
REQ-013 IDLE: falling edge of rx_s (previous 1, current 0) -> START, counter cleared.
REQ-014 START: at mid-bit, rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch, no strobes).
REQ-015 DATA: 8 samples shift into a shift register LSB first; after the 8th -> PARITY if PARITY_EN, else STOP.
REQ-016 PARITY: one sample; parity error = XOR(8 data bits, sampled bit) != 0.
REQ-017 STOP: one sample; rx_s=0 sets framing error.
REQ-018 Cycle after the stop sample: UART_errors_valid=1 and UART_errors = {framing, parity}; both strobes high for exactly one cycle.
REQ-019 UART_data_valid SHALL pulse and UART_data SHALL load only if both error bits are 0; otherwise UART_data holds its previous value.
REQ-020 UART_errors SHALL hold its value between frames until the next UART_errors_valid.
REQ-021 After the end of the frame: stop bit 1 -> IDLE; stop bit 0 -> BREAK.
REQ-022 BREAK: stay until rx_s=1, then -> IDLE; no new frame detected while in BREAK.
REQ-023 A falling edge on the same cycle as the exit to IDLE SHALL start a new frame (back-to-back frames, no idle bit needed beyond the stop bit).
REQ-024 Latency: stop-bit mid-sample to strobes = 1 clk; rx edge to FSM sees edge = 2 clk (synchronizer).

Reset
REQ-025 rst=1 at any clock edge SHALL force state IDLE, counters 0, shift register 0, synchronizer 1, UART_data=0x00, UART_errors=2'b00, both strobes 0.
REQ-026 Reset asserted mid-frame SHALL abort it with no strobes; the remainder of that frame on rx is not treated as a start unless a later falling edge occurs.

Verification (CLKS_PER_BIT=16, PARITY_EN=1 unless stated)
REQ-027 Send 0xA5 with parity bit 0 and stop bit 1 -> UART_data=0xA5, UART_data_valid pulse, UART_errors=00, UART_errors_valid pulse, same cycle.
REQ-028 Send 0x01 with parity bit 0 (wrong) -> UART_errors=01, no data strobe, UART_data keeps 0xA5.
REQ-029 Send 0x3C with stop bit 0, hold rx low 40 bits, release -> UART_errors=10 once; no further strobes until the next valid frame; a following 0x55 is received correctly.
REQ-030 Low pulse of 5 clk on idle rx -> no strobes, FSM back to IDLE.
REQ-031 Assert rst during the 4th data bit of 0xFF -> all outputs 0 next cycle, no strobes; the next frame 0x12 is received correctly.
REQ-032 PARITY_EN=0: send 0x80 and 0x7F back-to-back -> two data strobes 10*16 clk apart, values 0x80 then 0x7F.
